uart_pack_assembler: RTL and testbench
======================================

Name: uart_pack_assembler

Overview:
- Sits directly upstream of diff_freq_serial_out, between the UART receiver and the serial-output engine.
- Collects PACK_NUM consecutive UART bytes into one packet: output pattern (DATA_BIT bits), frequency pattern (DATA_BIT bits) and control byte.
- Presents the packet on a valid/ready interface.
- Discards partial packets after an inter-byte silence timeout, so a lost byte cannot misalign every later packet.

Parameters:
- DATA_BIT, 32, width of the output and frequency patterns; must be a multiple of 8.
- PACK_NUM, (DATA_BIT/8)*2+1, bytes per packet; derived, not to be overridden independently.
- TIMEOUT_CYCLES, 40000, clk cycles of rx silence inside a partial packet before it is discarded (~10 byte-times at 256 kBd / 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (PLL output, 100 MHz)
- rst  input  1  synchronous, active-high reset
- i_data  input  8  received UART byte, valid when i_rx_done_tick=1
- i_rx_done_tick  input  1  one-cycle pulse per received byte
- o_out_pattern  output  DATA_BIT  assembled output pattern
- o_freq_pattern  output  DATA_BIT  assembled frequency pattern
- o_ctrl  output  8  assembled control byte
- o_pack_valid  output  1  packet outputs valid; held until accepted
- i_pack_ready  input  1  downstream accepts the packet when high together with o_pack_valid
- o_busy  output  1  high while a partial packet is being collected
- o_timeout_tick  output  1  one-cycle pulse when a partial packet is discarded on timeout
- o_overrun_tick  output  1  one-cycle pulse when a byte is dropped because a packet is still pending

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - All outputs 0.
  - Byte counter 0, timer 0, state IDLE.
  - Any partial or pending packet is lost; no tick is generated.
- Byte mapping, with byte index k = 0..PACK_NUM-1 in arrival order and little-endian packing:
  - k = 0..DATA_BIT/8-1: o_out_pattern[8k+7:8k].
  - k = DATA_BIT/8..2*DATA_BIT/8-1: o_freq_pattern, same rule with k rebased to 0.
  - k = PACK_NUM-1: o_ctrl.
- Assembly uses an internal shift/capture register. Output registers update only on packet completion, so outputs are stable while o_pack_valid=1.
- State machine:
  - IDLE: a byte tick stores byte 0, sets count=1 and goes to COLLECT. If PACK_NUM==1, it completes directly.
  - COLLECT:
    - A byte tick stores the byte, increments count and clears the timer.
    - The tick carrying byte PACK_NUM-1 copies the packet to the output registers, sets o_pack_valid=1 on the next cycle, clears count and goes to HOLD. Latency from final tick to o_pack_valid is 1 cycle.
    - With no tick, the timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no tick that cycle, the next cycle has count=0, state IDLE and o_timeout_tick=1 for one cycle.
  - HOLD:
    - o_pack_valid=1. A clock edge with i_pack_ready=1 completes the handshake: o_pack_valid=0 on the next cycle and state goes to IDLE.
    - A byte tick in HOLD with i_pack_ready=0 is dropped and pulses o_overrun_tick on the next cycle.
    - A byte tick in the same cycle as the handshake is accepted as byte 0 of the next packet, with state going to COLLECT and count=1.
- o_busy = 1 exactly in COLLECT.
- Simultaneous byte tick and timer expiry: the byte wins. It is stored, the timer clears and no timeout occurs.
- i_pack_ready while o_pack_valid=0 has no effect.
- Widths:
  - Byte counter is $clog2(PACK_NUM+1) bits.
  - Timer is $clog2(TIMEOUT_CYCLES+1) bits, saturating logic not needed because it clears on expiry.
- No timeout applies in IDLE or HOLD.

Decomposition:
- Package diff_freq_pkg holds DATA_BIT, PACK_NUM, BYTES_PER_PATTERN (DATA_BIT/8), the state encoding (IDLE, COLLECT, HOLD) and the byte-offset constants.
- Shared with diff_freq_serial_out and the top-level wrapper.
- One sub-module, rx_gap_timer:
  - Inputs: clk, rst, clear, enable.
  - Output: one-cycle expire pulse.
  - Parameter: TIMEOUT_CYCLES.
- The FSM and capture registers stay in uart_pack_assembler.

Test Plan:
1. Nine bytes 0x78,0x56,0x34,0x12,0xEF,0xCD,0xAB,0x89,0x05 at 100-cycle spacing, ready=1 -> one cycle after 9th tick: o_out_pattern=0x12345678, o_freq_pattern=0x89ABCDEF, o_ctrl=0x05, o_pack_valid=1 for 1 cycle; o_busy high from tick 1 until tick 9.
2. Four bytes, then silence with TIMEOUT_CYCLES=50 -> o_timeout_tick pulses exactly 50 cycles after the 4th tick, o_busy=0. A following full 9-byte packet assembles correctly with no stale data.
3. Packet completes with ready=0, 10th byte 0xAA arrives -> o_overrun_tick=1 for one cycle, outputs unchanged, o_pack_valid stays 1. Raising ready returns the state to IDLE.
4. Byte tick in the same cycle as the valid&&ready handshake -> that byte becomes o_out_pattern[7:0] of the next packet, no overrun tick.
5. Byte tick arriving exactly on the expiry cycle (TIMEOUT_CYCLES-1 idle cycles after the previous tick) -> no o_timeout_tick, count advances.
6. rst=1 for one cycle after byte 6 -> all outputs 0 and no ticks. A subsequent 9-byte packet assembles correctly.

Source files
------------

// File: rtl/diff_freq_pkg.sv
// Purpose: shared constants, state encoding and packet payload type for the
//          UART packet assembler and the serial-output engine it feeds.
// Ports:   none (package).
package diff_freq_pkg;

  localparam int unsigned DATA_BIT          = 32;
  localparam int unsigned BYTES_PER_PATTERN = DATA_BIT / 8;
  localparam int unsigned PACK_NUM          = BYTES_PER_PATTERN * 2 + 1;
  localparam int unsigned PACK_W            = PACK_NUM * 8;
  localparam int unsigned CNT_W             = $clog2(PACK_NUM + 1);

  // Byte offsets of each field inside a packet, in arrival order
  localparam int unsigned OUT_BYTE_OFS  = 0;
  localparam int unsigned FREQ_BYTE_OFS = BYTES_PER_PATTERN;
  localparam int unsigned CTRL_BYTE_OFS = PACK_NUM - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } pack_state_e;

  // Packed in arrival order: byte 0 lands in out[7:0], last byte is ctrl
  typedef struct packed {
    logic [7:0]          ctrl;
    logic [DATA_BIT-1:0] freq;
    logic [DATA_BIT-1:0] out;
  } pack_t;

endpackage

// File: rtl/uart_pack_assembler_if.sv
// Purpose: valid/ready packet bus between the assembler (master) and the
//          serial-output engine (slave).
// Signals: o_out_pattern, o_freq_pattern, o_ctrl, o_pack_valid (master->slave),
//          i_pack_ready (slave->master).
interface uart_pack_assembler_if;
  import diff_freq_pkg::*;

  logic [DATA_BIT-1:0] o_out_pattern;
  logic [DATA_BIT-1:0] o_freq_pattern;
  logic [7:0]          o_ctrl;
  logic                o_pack_valid;
  logic                i_pack_ready;

  modport master (
    output o_out_pattern,
    output o_freq_pattern,
    output o_ctrl,
    output o_pack_valid,
    input  i_pack_ready
  );

  modport slave (
    input  o_out_pattern,
    input  o_freq_pattern,
    input  o_ctrl,
    input  o_pack_valid,
    output i_pack_ready
  );

endinterface

// File: rtl/uart_pack_assembler_rx_gap_timer.sv
// Purpose: counts idle cycles between received bytes and flags the cycle on
//          which the silence limit is reached.
// Ports:   clk, rst (sync, active-high), clear (restart count), enable (count
//          while high), expire (combinational one-cycle pulse).
module rx_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;

  // A clear in the same cycle suppresses expiry, so a late byte still wins
  assign expire = enable && !clear && (tmr_q == TMR_LAST);

  // Next count: restart on clear, disable or expiry
  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if (clear || !enable || expire) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/uart_pack_assembler.sv
// Purpose: gathers PACK_NUM UART bytes into one packet (output pattern,
//          frequency pattern, control byte) and offers it on a valid/ready bus;
//          partial packets are dropped after an inter-byte silence timeout.
// Ports:   clk, rst (sync, active-high); i_data/i_rx_done_tick (received byte);
//          pack_bus (packet bus, master side); o_busy (collecting);
//          o_timeout_tick (partial packet discarded); o_overrun_tick (byte
//          dropped while a packet is pending).
module uart_pack_assembler
  import diff_freq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_data,
  input  logic                 i_rx_done_tick,
  uart_pack_assembler_if.master pack_bus,
  output logic                 o_busy,
  output logic                 o_timeout_tick,
  output logic                 o_overrun_tick
);

  // Holds every byte except the last, which is taken straight from i_data
  localparam int unsigned SHIFT_W = PACK_W - 8;

  pack_state_e        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  pack_t              pack_q,  pack_d;
  logic               valid_q, valid_d;
  logic               busy_q,  busy_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic               take_c;
  logic               expire_c;
  logic [PACK_W-1:0]  packet_c;

  assign packet_c = {i_data, shift_q};

  // Silence timer only runs while a partial packet is open
  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (i_rx_done_tick || (state_q != COLLECT)),
    .enable (state_q == COLLECT),
    .expire (expire_c)
  );

  // Next-state, capture and tick logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    pack_d    = pack_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    take_c    = 1'b0;

    case (state_q)
      IDLE: begin
        take_c = i_rx_done_tick;
      end
      COLLECT: begin
        if (i_rx_done_tick) begin
          take_c = 1'b1;
        end else if (expire_c) begin
          state_d   = IDLE;
          count_d   = '0;
          timeout_d = 1'b1;
        end
      end
      HOLD: begin
        // A byte coinciding with the handshake opens the next packet
        if (pack_bus.i_pack_ready) begin
          state_d = IDLE;
          take_c  = i_rx_done_tick;
        end else if (i_rx_done_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    if (take_c) begin
      shift_d = {i_data, shift_q[SHIFT_W-1:8]};
      if (count_q == CNT_W'(PACK_NUM - 1)) begin
        pack_d.out  = packet_c[OUT_BYTE_OFS*8  +: DATA_BIT];
        pack_d.freq = packet_c[FREQ_BYTE_OFS*8 +: DATA_BIT];
        pack_d.ctrl = packet_c[CTRL_BYTE_OFS*8 +: 8];
        count_d     = '0;
        state_d     = HOLD;
      end else begin
        count_d = count_q + CNT_W'(1);
        state_d = COLLECT;
      end
    end

    valid_d = (state_d == HOLD);
    busy_d  = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      pack_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      pack_q    <= pack_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign pack_bus.o_out_pattern  = pack_q.out;
  assign pack_bus.o_freq_pattern = pack_q.freq;
  assign pack_bus.o_ctrl         = pack_q.ctrl;
  assign pack_bus.o_pack_valid   = valid_q;
  assign o_busy                  = busy_q;
  assign o_timeout_tick          = timeout_q;
  assign o_overrun_tick          = overrun_q;

endmodule

// File: tb/tb_uart_pack_assembler.sv
// Purpose: scoreboard bench for uart_pack_assembler with a short silence limit.
module tb_uart_pack_assembler;
  import diff_freq_pkg::*;

  localparam int unsigned TMO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_rx_done_tick;
  logic       o_busy;
  logic       o_timeout_tick;
  logic       o_overrun_tick;

  uart_pack_assembler_if pack_bus();

  uart_pack_assembler #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (i_data),
    .i_rx_done_tick (i_rx_done_tick),
    .pack_bus       (pack_bus),
    .o_busy         (o_busy),
    .o_timeout_tick (o_timeout_tick),
    .o_overrun_tick (o_overrun_tick)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_to  = 0;
  int    n_ovr = 0;
  pack_t exp_q[$];
  pack_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after posedge, so negedge sees what the next posedge uses
  always @(negedge clk) begin
    if (o_timeout_tick) n_to++;
    if (o_overrun_tick) n_ovr++;
    if (!rst && pack_bus.o_pack_valid && pack_bus.i_pack_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pkt", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_out",  64'(pack_bus.o_out_pattern),  64'(mon_e.out));
        check_eq("sb_freq", 64'(pack_bus.o_freq_pattern), 64'(mon_e.freq));
        check_eq("sb_ctrl", 64'(pack_bus.o_ctrl),         64'(mon_e.ctrl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data         = b;
    i_rx_done_tick = 1'b1;
    step();
    i_rx_done_tick = 1'b0;
  endtask

  // Sends bytes first..PACK_NUM-1 of p with gap idle cycles between them
  task automatic send_pack(input pack_t p, input int gap, input int first);
    logic [PACK_W-1:0] bv;
    bv = p;
    exp_q.push_back(p);
    for (int k = first; k < int'(PACK_NUM); k++) begin
      send_byte(bv[k*8 +: 8]);
      if (k < int'(PACK_NUM) - 1) begin
        check_eq("busy_mid", 64'(o_busy), 64'd1);
        repeat (gap) step();
      end
    end
    check_eq("valid_lat", 64'(pack_bus.o_pack_valid), 64'd1);
    check_eq("busy_done", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pack_t p;
    int    to0;
    int    ovr0;
    int    hit_at;

    rst                   = 1'b1;
    i_data                = 8'h00;
    i_rx_done_tick        = 1'b0;
    pack_bus.i_pack_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_out",   64'(pack_bus.o_out_pattern),  64'd0);
    check_eq("rst_freq",  64'(pack_bus.o_freq_pattern), 64'd0);
    check_eq("rst_ctrl",  64'(pack_bus.o_ctrl),         64'd0);
    check_eq("rst_valid", 64'(pack_bus.o_pack_valid),   64'd0);
    check_eq("rst_busy",  64'(o_busy),                  64'd0);
    check_eq("rst_ticks", 64'({o_timeout_tick, o_overrun_tick}), 64'd0);
    rst = 1'b0;

    // Basic packet, ready held high
    pack_bus.i_pack_ready = 1'b1;
    p = '{ctrl: 8'h05, freq: 32'h89ABCDEF, out: 32'h12345678};
    send_pack(p, 40, 0);
    step();
    check_eq("valid_one_cycle", 64'(pack_bus.o_pack_valid), 64'd0);

    // Timeout after four bytes, then a clean packet
    to0 = n_to;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'(8'hC0 + k));
      if (k < 3) repeat (10) step();
    end
    hit_at = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (o_timeout_tick && hit_at == 0) hit_at = k;
    end
    check_eq("timeout_delay", 64'(hit_at), 64'(TMO));
    check_eq("timeout_count", 64'(n_to - to0), 64'd1);
    check_eq("timeout_busy",  64'(o_busy), 64'd0);
    p = '{ctrl: 8'h3C, freq: 32'hDEADBEEF, out: 32'hA5A55A5A};
    send_pack(p, 20, 0);
    step();

    // Overrun while a packet is pending
    pack_bus.i_pack_ready = 1'b0;
    p = '{ctrl: 8'h7E, freq: 32'h01020304, out: 32'hCAFEF00D};
    send_pack(p, 20, 0);
    ovr0 = n_ovr;
    send_byte(8'hAA);
    check_eq("ovr_tick",   64'(o_overrun_tick), 64'd1);
    check_eq("ovr_out",    64'(pack_bus.o_out_pattern), 64'(32'hCAFEF00D));
    check_eq("ovr_ctrl",   64'(pack_bus.o_ctrl), 64'(8'h7E));
    step();
    check_eq("ovr_tick_off", 64'(o_overrun_tick), 64'd0);
    check_eq("ovr_count",    64'(n_ovr - ovr0), 64'd1);
    check_eq("ovr_valid",    64'(pack_bus.o_pack_valid), 64'd1);
    pack_bus.i_pack_ready = 1'b1;
    step();
    check_eq("ovr_release_valid", 64'(pack_bus.o_pack_valid), 64'd0);
    check_eq("ovr_release_busy",  64'(o_busy), 64'd0);

    // Byte arriving on the handshake cycle opens the next packet
    pack_bus.i_pack_ready = 1'b0;
    p = '{ctrl: 8'h99, freq: 32'h55667788, out: 32'h11223344};
    send_pack(p, 20, 0);
    ovr0                  = n_ovr;
    i_data                = 8'h11;
    i_rx_done_tick        = 1'b1;
    pack_bus.i_pack_ready = 1'b1;
    step();
    i_rx_done_tick        = 1'b0;
    pack_bus.i_pack_ready = 1'b0;
    check_eq("hs_valid", 64'(pack_bus.o_pack_valid), 64'd0);
    check_eq("hs_busy",  64'(o_busy), 64'd1);
    p = '{ctrl: 8'h42, freq: 32'hFEDCBA98, out: 32'h76543211};
    send_pack(p, 20, 1);
    check_eq("hs_no_ovr", 64'(n_ovr - ovr0), 64'd0);
    pack_bus.i_pack_ready = 1'b1;
    step();

    // Every byte lands on the would-be expiry cycle
    to0 = n_to;
    p = '{ctrl: 8'hE7, freq: 32'h0F1E2D3C, out: 32'h4B5A6978};
    send_pack(p, TMO - 1, 0);
    check_eq("edge_no_timeout", 64'(n_to - to0), 64'd0);
    step();

    // Reset mid-packet
    for (int k = 0; k < 6; k++) begin
      send_byte(8'(8'h60 + k));
      repeat (5) step();
    end
    to0  = n_to;
    ovr0 = n_ovr;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    check_eq("mrst_out",   64'(pack_bus.o_out_pattern),  64'd0);
    check_eq("mrst_freq",  64'(pack_bus.o_freq_pattern), 64'd0);
    check_eq("mrst_ctrl",  64'(pack_bus.o_ctrl),         64'd0);
    check_eq("mrst_valid", 64'(pack_bus.o_pack_valid),   64'd0);
    check_eq("mrst_busy",  64'(o_busy),                  64'd0);
    repeat (TMO + 10) step();
    check_eq("mrst_no_ticks", 64'((n_to - to0) + (n_ovr - ovr0)), 64'd0);
    p = '{ctrl: 8'h81, freq: 32'h13579BDF, out: 32'h2468ACE0};
    send_pack(p, 20, 0);
    repeat (5) step();

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
